// File: rtl/vc_alloc_rr_if.sv
// rtl/vc_alloc_rr_if.sv - request/grant/release bundle between route compute, VC allocator and switch allocation
interface vc_alloc_rr_if #(
  parameter int NUM_PORTS         = 6,
  parameter int LANES_PER_CHANNEL = 2
);
  localparam int NV = NUM_PORTS * LANES_PER_CHANNEL;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW = (LANES_PER_CHANNEL > 1) ? $clog2(LANES_PER_CHANNEL) : 1;

  logic [NV-1:0]    req_valid;
  logic [NV*PW-1:0] req_port;
  logic [NV-1:0]    req_esc;
  logic [NV-1:0]    rel;
  logic [NV-1:0]    gnt;
  logic [NV*LW-1:0] gnt_lane;
  logic [NV-1:0]    vc_busy;
  logic             err_rel;

  modport master (
    output req_valid, req_port, req_esc, rel,
    input  gnt, gnt_lane, vc_busy, err_rel
  );

  modport slave (
    input  req_valid, req_port, req_esc, rel,
    output gnt, gnt_lane, vc_busy, err_rel
  );
endinterface

// File: rtl/vc_alloc_rr.sv
// rtl/vc_alloc_rr.sv - round-robin VC allocator with lane occupancy; ESCAPE_VC_EN reserves lane 0 as escape VC
module vc_alloc_rr #(
  parameter int NUM_PORTS         = 6,
  parameter int LANES_PER_CHANNEL = 2
) (
  input logic         clk,
  input logic         reset,
  vc_alloc_rr_if.slave bus
);
  localparam int L   = LANES_PER_CHANNEL;
  localparam int NV  = NUM_PORTS * L;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW  = (L > 1) ? $clog2(L) : 1;
  localparam int NVW = (NV > 1) ? $clog2(NV) : 1;

  logic [NV-1:0]    gnt_q;
  logic [NV*LW-1:0] lane_q;
  logic [NV-1:0]    busy_q;
  logic             err_q;
  logic [NVW-1:0]   rr_ptr [NUM_PORTS];

  logic [NV-1:0]    gnt_d;
  logic [NV*LW-1:0] lane_d;
  logic [NV-1:0]    busy_set;
  logic [NVW-1:0]   ptr_d  [NUM_PORTS];

  // Returns {found, lane}: lowest lane whose blocked bit is clear.
  function automatic logic [LW:0] pick_lane(input logic [L-1:0] blocked);
    logic [LW:0] res;
    res = '0;
    for (int l = L - 1; l >= 0; l--) begin
      if (!blocked[l]) res = {1'b1, LW'(l)};
    end
    return res;
  endfunction

`ifdef ESCAPE_VC_EN
  // Lanes a requester may NOT use: escape traffic owns lane 0 alone.
  function automatic logic [L-1:0] class_mask(input logic esc);
    logic [L-1:0] m;
    if (esc) begin
      m    = '1;
      m[0] = 1'b0;
    end else begin
      m    = '0;
      m[0] = 1'b1;
    end
    return m;
  endfunction
`else
  logic unused_esc;
  assign unused_esc = ^bus.req_esc;
`endif

  always_comb begin
    logic        found;
    logic [LW:0] pick;
    logic [L-1:0] blocked;
    int          idx;
    gnt_d    = '0;
    lane_d   = '0;
    busy_set = '0;
    found    = 1'b0;
    pick     = '0;
    blocked  = '0;
    idx      = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      ptr_d[p] = rr_ptr[p];
      found    = 1'b0;
      // Requesters whose lane class is full are skipped, not allowed to block the port.
      for (int k = 0; k < NV; k++) begin
        idx = (int'(rr_ptr[p]) + k) % NV;
`ifdef ESCAPE_VC_EN
        blocked = busy_q[p*L +: L] | class_mask(bus.req_esc[idx]);
`else
        blocked = busy_q[p*L +: L];
`endif
        pick = pick_lane(blocked);
        if (!found && bus.req_valid[idx] && !gnt_q[idx] &&
            int'(bus.req_port[idx*PW +: PW]) == p && pick[LW]) begin
          found                          = 1'b1;
          gnt_d[idx]                     = 1'b1;
          lane_d[idx*LW +: LW]           = pick[LW-1:0];
          busy_set[p*L + int'(pick[LW-1:0])] = 1'b1;
          ptr_d[p]                       = NVW'((idx + 1) % NV);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q  <= '0;
      lane_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) rr_ptr[p] <= '0;
    end else begin
      gnt_q  <= gnt_d;
      lane_q <= lane_d;
      busy_q <= (busy_q & ~bus.rel) | busy_set;
      if (|(bus.rel & ~busy_q)) err_q <= 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) rr_ptr[p] <= ptr_d[p];
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_lane = lane_q;
  assign bus.vc_busy  = busy_q;
  assign bus.err_rel  = err_q;
endmodule

// File: tb/tb_vc_alloc_rr.sv
// tb/tb_vc_alloc_rr.sv - randomized and directed bench for vc_alloc_rr against a behavioural model
module tb_vc_alloc_rr;
  localparam int NUM_PORTS = 6;
  localparam int L         = 2;
  localparam int NV        = NUM_PORTS * L;
  localparam int PW        = 3;
  localparam int LW        = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_alloc_rr_if #(.NUM_PORTS(NUM_PORTS), .LANES_PER_CHANNEL(L)) bus ();
  vc_alloc_rr #(.NUM_PORTS(NUM_PORTS), .LANES_PER_CHANNEL(L)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit m_busy [NV];
  int m_ptr  [NUM_PORTS];
  bit m_err;
  bit m_gnt  [NV];
  int m_lane [NV];

  bit rq_v    [NV];
  int rq_port [NV];
  bit rq_esc  [NV];
  bit rl      [NV];
  bit drop_nx [NV];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit lane_ok(input int l, input bit esc);
    bit ok;
    ok = (l >= 0) || esc;
`ifdef ESCAPE_VC_EN
    ok = esc ? (l == 0) : (l != 0);
`endif
    return ok;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < NV; i++) begin
      rq_v[i] = 0; rq_port[i] = 0; rq_esc[i] = 0; rl[i] = 0; drop_nx[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NV; i++) begin
      bus.req_valid[i]         = rq_v[i];
      bus.req_port[i*PW +: PW] = PW'(rq_port[i]);
      bus.req_esc[i]           = rq_esc[i];
      bus.rel[i]               = rl[i];
    end
  endtask

  // One clock edge of the allocator as described: releases, then per-port RR pick.
  task automatic model_edge();
    bit nb [NV];
    bit ng [NV];
    int nl [NV];
    int i;
    int lane;
    if (reset) begin
      for (int o = 0; o < NV; o++) begin m_busy[o] = 0; m_gnt[o] = 0; m_lane[o] = 0; end
      for (int p = 0; p < NUM_PORTS; p++) m_ptr[p] = 0;
      m_err = 0;
      return;
    end
    nb = m_busy;
    for (int o = 0; o < NV; o++) begin ng[o] = 0; nl[o] = 0; end
    for (int o = 0; o < NV; o++) begin
      if (rl[o]) begin
        if (!m_busy[o]) m_err = 1;
        nb[o] = 0;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < NV; k++) begin
        i = (m_ptr[p] + k) % NV;
        if (!rq_v[i] || m_gnt[i] || rq_port[i] != p) continue;
        lane = -1;
        for (int l = 0; l < L; l++)
          if (lane < 0 && lane_ok(l, rq_esc[i]) && !m_busy[p*L + l]) lane = l;
        if (lane >= 0) begin
          ng[i] = 1; nl[i] = lane; nb[p*L + lane] = 1;
          m_ptr[p] = (i + 1) % NV;
          break;
        end
      end
    end
    m_busy = nb; m_gnt = ng; m_lane = nl;
  endtask

  task automatic step();
    logic [NV-1:0]    eg;
    logic [NV-1:0]    eb;
    logic [NV*LW-1:0] el;
    drive();
    model_edge();
    @(posedge clk);
    #1;
    for (int o = 0; o < NV; o++) begin
      eg[o] = m_gnt[o];
      eb[o] = m_busy[o];
      el[o*LW +: LW] = LW'(m_lane[o]);
    end
    check("gnt", bus.gnt, eg);
    check("gnt_lane", bus.gnt_lane, el);
    check("vc_busy", bus.vc_busy, eb);
    check("err_rel", bus.err_rel, m_err);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin rq_v[i] = 1; rq_port[i] = i % NUM_PORTS; end
    repeat (2) begin
      step();
      check("rst_gnt", bus.gnt, 0);
      check("rst_busy", bus.vc_busy, 0);
      check("rst_err", bus.err_rel, 0);
    end
    reset = 1'b0;
    clear_inputs();
    step();

`ifndef ESCAPE_VC_EN
    rq_v[3] = 1; rq_port[3] = 2;
    step();
    check("single_gnt", bus.gnt, 12'h008);
    check("single_lane", bus.gnt_lane[3], 0);
    check("single_busy", bus.vc_busy, 12'h010);
    step();
    check("single_mask", bus.gnt, 0);
    rq_v[3] = 0;
    step();
    check("single_quiet", bus.gnt, 0);
    rl[4] = 1;
    step();
    rl[4] = 0;
    check("single_rel", bus.vc_busy, 0);

    rq_v[0] = 1; rq_port[0] = 1;
    rq_v[2] = 1; rq_port[2] = 1;
    rq_v[4] = 1; rq_port[4] = 1;
    step();
    check("cont_gnt0", bus.gnt, 12'h001);
    check("cont_lane0", bus.gnt_lane[0], 0);
    step();
    check("cont_gnt2", bus.gnt, 12'h004);
    check("cont_lane2", bus.gnt_lane[2], 1);
    rq_v[0] = 0;
    step();
    check("cont_full", bus.gnt, 0);
    rq_v[2] = 0;
    rl[3] = 1;
    step();
    check("cont_relcyc", bus.gnt, 0);
    rl[3] = 0;
    step();
    check("cont_gnt4", bus.gnt, 12'h010);
    check("cont_lane4", bus.gnt_lane[4], 1);
    rq_v[4] = 0;
    rl[2] = 1; rl[3] = 1;
    step();
    clear_inputs();

    rq_v[1] = 1; rq_port[1] = 0;
    rq_v[5] = 1; rq_port[5] = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("fair_gnt", bus.gnt, (n % 2) ? 12'h020 : 12'h002);
      rl[0] = 0; rl[1] = 0;
      rl[n % 2] = 1;
    end
    rq_v[1] = 0; rq_v[5] = 0;
    step();
    clear_inputs();
    step();

    rq_v[11] = 1; rq_port[11] = 3;
    step();
    check("wrap_g11", bus.gnt, 12'h800);
    rq_v[11] = 0;
    step();
    rq_v[11] = 1; rq_v[0] = 1; rq_port[0] = 3;
    step();
    check("wrap_g0", bus.gnt, 12'h001);
    check("wrap_lane0", bus.gnt_lane[0], 1);
    clear_inputs();
    rl[6] = 1; rl[7] = 1;
    step();
    clear_inputs();

    rq_v[6] = 1; rq_port[6] = 7;
    rq_v[7] = 1; rq_port[7] = 6;
    repeat (4) begin
      step();
      check("bad_port", bus.gnt, 0);
    end
    clear_inputs();
`else
    rq_v[0] = 1; rq_port[0] = 0; rq_esc[0] = 1;
    rq_v[2] = 1; rq_port[2] = 0; rq_esc[2] = 0;
    step();
    check("esc_gnt0", bus.gnt, 12'h001);
    check("esc_lane0", bus.gnt_lane[0], 0);
    step();
    check("esc_gnt2", bus.gnt, 12'h004);
    check("esc_lane2", bus.gnt_lane[2], 1);
    clear_inputs();
    rl[1] = 1;
    step();
    rl[1] = 0;
    rq_v[4] = 1; rq_port[4] = 0; rq_esc[4] = 1;
    repeat (3) begin
      step();
      check("esc_blocked", bus.gnt, 0);
    end
    rq_v[6] = 1; rq_port[6] = 0; rq_esc[6] = 0;
    step();
    check("esc_skip", bus.gnt, 12'h040);
    check("esc_skip_lane", bus.gnt_lane[6], 1);
    clear_inputs();
    rl[0] = 1; rl[1] = 1;
    step();
    clear_inputs();
`endif

    step();
    check("err_pre", bus.err_rel, 0);
    rl[9] = 1;
    step();
    rl[9] = 0;
    check("err_set", bus.err_rel, 1);
    repeat (3) begin
      step();
      check("err_sticky", bus.err_rel, 1);
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NV; i++) begin
        if (m_gnt[i]) drop_nx[i] = 1;
        else if (drop_nx[i]) begin rq_v[i] = 0; drop_nx[i] = 0; end
        else if (!rq_v[i] && $urandom_range(0, 3) == 0) begin
          rq_v[i]    = 1;
          rq_port[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
          rq_esc[i]  = 1'($urandom_range(0, 1));
        end else if (rq_v[i] && rq_port[i] >= NUM_PORTS && $urandom_range(0, 7) == 0)
          rq_v[i] = 0;
        rl[i] = m_busy[i] && ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 299) == 0) rl[$urandom_range(0, NV - 1)] = 1;
      step();
    end

    clear_inputs();
    for (int i = 0; i < NV; i++) begin rq_v[i] = 1; rq_port[i] = i % NUM_PORTS; rq_esc[i] = i[0]; end
    step();
    check("busy_before_rst", bus.vc_busy != 0, 1);
    reset = 1'b1;
    step();
    check("rst_mid_busy", bus.vc_busy, 0);
    check("rst_mid_err", bus.err_rel, 0);
    reset = 1'b0;
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
